// File: rtl/booth_sequencer.sv
// Booth multiplier sequencer: takes a signed operand pair, feeds the
// multiplicand and then the multiplier to an external Booth multiplier,
// collects the two result bytes it dumps, and holds the product until consumed.
module booth_sequencer #(
    parameter int BUS_WIDTH = 8,
    parameter int TIMEOUT   = 63
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   op_valid,
    output logic                   op_ready,
    input  logic [BUS_WIDTH-1:0]   op_a,
    input  logic [BUS_WIDTH-1:0]   op_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [2*BUS_WIDTH-1:0] res_product,
    output logic                   res_timeout,
    output logic [BUS_WIDTH-1:0]   mult_inbus,
    output logic                   mult_beginsig,
    output logic                   mult_locksig,
    input  logic [BUS_WIDTH-1:0]   mult_outbus,
    input  logic                   mult_endsig,
    output logic                   busy
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_M,
        S_LOAD_Q,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t                 state_q, state_d;
    logic [BUS_WIDTH-1:0]   a_q, a_d;
    logic [BUS_WIDTH-1:0]   b_q, b_d;
    logic [BUS_WIDTH-1:0]   h0_q, h0_d;
    logic [BUS_WIDTH-1:0]   h1_q, h1_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2*BUS_WIDTH-1:0] prod_q, prod_d;
    logic                   tout_q, tout_d;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            h0_q    <= '0;
            h1_q    <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            h0_q    <= h0_d;
            h1_q    <= h1_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            tout_q  <= tout_d;
        end
    end

    // Next-state logic and registered datapath updates
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        h0_d    = h0_q;
        h1_d    = h1_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        tout_d  = tout_q;
        case (state_q)
            S_IDLE: begin
                if (op_valid && op_ready) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    state_d = S_LOAD_M;
                end
            end
            S_LOAD_M: state_d = S_LOAD_Q;
            S_LOAD_Q: begin
                cnt_d   = '0;
                h0_d    = '0;
                h1_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                h1_d  = h0_q;
                h0_d  = mult_outbus;
                cnt_d = cnt_q + CW'(1);
                // A genuine completion beats a coincident timeout
                if (mult_endsig) begin
                    prod_d  = {h1_q, h0_q};
                    tout_d  = 1'b0;
                    state_d = S_HOLD;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    prod_d  = '0;
                    tout_d  = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state
    always_comb begin
        op_ready      = (state_q == S_IDLE) && !rst;
        busy          = (state_q != S_IDLE);
        res_valid     = (state_q == S_HOLD);
        res_product   = prod_q;
        res_timeout   = tout_q;
        mult_beginsig = (state_q == S_LOAD_M);
        mult_locksig  = (state_q == S_LOAD_M) || (state_q == S_LOAD_Q) ||
                        (state_q == S_WAIT);
        mult_inbus    = '0;
        if (state_q == S_LOAD_M) mult_inbus = a_q;
        if (state_q == S_LOAD_Q) mult_inbus = b_q;
    end

endmodule

// File: tb/tb_booth_sequencer.sv
// Directed bench for booth_sequencer with a small behavioural multiplier model.
module tb_booth_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic [7:0]  op_a, op_b;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_product;
    logic        res_timeout;
    logic [7:0]  mult_inbus;
    logic        mult_beginsig;
    logic        mult_locksig;
    logic [7:0]  mult_outbus;
    logic        mult_endsig;
    logic        busy;

    int total = 0;
    int bad   = 0;

    booth_sequencer #(.BUS_WIDTH(8), .TIMEOUT(63)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_product(res_product), .res_timeout(res_timeout),
        .mult_inbus(mult_inbus), .mult_beginsig(mult_beginsig),
        .mult_locksig(mult_locksig), .mult_outbus(mult_outbus),
        .mult_endsig(mult_endsig), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation. The model captures the operands off mult_inbus,
    // multiplies them, and dumps the high byte, then the low byte, then
    // raises mult_endsig on WAIT cycle n_wait (if end_en).
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input int n_wait, input bit end_en, input int hold_cyc,
                          input logic [15:0] exp_prod, input logic exp_to);
        logic signed [7:0]  m, q;
        logic signed [15:0] p;
        check({tag, ".op_ready"}, 32'(op_ready), 32'd1);
        op_valid = 1'b1; op_a = a; op_b = b;
        tick();                                 // LOAD_M
        op_valid = 1'b0;
        check({tag, ".begin"}, 32'(mult_beginsig), 32'd1);
        check({tag, ".inbus_m"}, 32'(mult_inbus), 32'(a));
        check({tag, ".lock"}, 32'(mult_locksig), 32'd1);
        m = mult_inbus;
        tick();                                 // LOAD_Q
        check({tag, ".begin_lq"}, 32'(mult_beginsig), 32'd0);
        check({tag, ".inbus_q"}, 32'(mult_inbus), 32'(b));
        q = mult_inbus;
        p = m * q;
        tick();                                 // first WAIT cycle
        for (int i = 1; i <= n_wait; i++) begin
            mult_outbus = 8'h00;
            mult_endsig = 1'b0;
            if (end_en && i == n_wait - 2) mult_outbus = p[15:8];
            if (end_en && i == n_wait - 1) mult_outbus = p[7:0];
            if (end_en && i == n_wait)     mult_endsig = 1'b1;
            if (i == 1) check({tag, ".begin_w"}, 32'(mult_beginsig), 32'd0);
            if (i == 2 || i == n_wait) begin
                check({tag, ".inbus_w"}, 32'(mult_inbus), 32'd0);
                check({tag, ".rv_w"}, 32'(res_valid), 32'd0);
                check({tag, ".rdy_w"}, 32'(op_ready), 32'd0);
            end
            tick();
        end
        mult_outbus = 8'h00;
        mult_endsig = 1'b0;
        for (int k = 0; k < hold_cyc; k++) begin
            check({tag, ".rv"}, 32'(res_valid), 32'd1);
            check({tag, ".prod"}, 32'(res_product), 32'(exp_prod));
            check({tag, ".tout"}, 32'(res_timeout), 32'(exp_to));
            check({tag, ".rdy_h"}, 32'(op_ready), 32'd0);
            check({tag, ".lock_h"}, 32'(mult_locksig), 32'd0);
            tick();
        end
        check({tag, ".rv_last"}, 32'(res_valid), 32'd1);
        check({tag, ".prod_last"}, 32'(res_product), 32'(exp_prod));
        // Consume the result while offering a new pair: it must not be taken.
        res_ready = 1'b1;
        op_valid  = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, ".idle_after"}, 32'(busy), 32'd0);
        check({tag, ".rv_after"}, 32'(res_valid), 32'd0);
        op_valid = 1'b0;
        #1;
        $display("op %s a=%02h b=%02h wait=%0d prod=%04h tout=%0b", tag, a, b, n_wait,
                 res_product, res_timeout);
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; op_a = '0; op_b = '0;
        res_ready = 1'b0; mult_outbus = '0; mult_endsig = 1'b0;
        tick(); tick();
        check("rst.op_ready", 32'(op_ready), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.res_valid", 32'(res_valid), 32'd0);
        check("rst.prod", 32'(res_product), 32'd0);
        check("rst.lock", 32'(mult_locksig), 32'd0);
        check("rst.begin", 32'(mult_beginsig), 32'd0);
        rst = 1'b0;
        #1;
        check("rst.op_ready_after", 32'(op_ready), 32'd1);
        $display("reset released op_ready=%0b", op_ready);

        // Stray endsig in IDLE must be ignored
        mult_endsig = 1'b1;
        tick();
        mult_endsig = 1'b0;
        check("idle.endsig_busy", 32'(busy), 32'd0);

        run_op("3x5",    8'h03, 8'h05, 4,  1'b1, 1,  16'h000F, 1'b0);
        run_op("m1x7",   8'hFF, 8'h07, 6,  1'b1, 1,  16'hFFF9, 1'b0);
        run_op("80x80",  8'h80, 8'h80, 3,  1'b1, 10, 16'h4000, 1'b0);
        run_op("tmo",    8'h12, 8'h34, 64, 1'b0, 2,  16'h0000, 1'b1);
        run_op("end_tmo",8'h7F, 8'h81, 64, 1'b1, 1,  16'hC0FF, 1'b0);

        // Reset in the middle of WAIT
        op_valid = 1'b1; op_a = 8'h09; op_b = 8'h09;
        tick(); op_valid = 1'b0;
        tick(); tick(); tick();                 // now in WAIT
        check("mid.busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        check("mid.busy", 32'(busy), 32'd0);
        check("mid.rv", 32'(res_valid), 32'd0);
        check("mid.tout", 32'(res_timeout), 32'd0);
        check("mid.prod", 32'(res_product), 32'd0);
        check("mid.lock", 32'(mult_locksig), 32'd0);
        check("mid.inbus", 32'(mult_inbus), 32'd0);
        check("mid.op_ready", 32'(op_ready), 32'd0);
        rst = 1'b0;
        #1;
        $display("mid-wait reset busy=%0b res_valid=%0b", busy, res_valid);
        run_op("2x2",    8'h02, 8'h02, 5,  1'b1, 1,  16'h0004, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
